fb_writer: RTL and testbench

- Write-side engine for the 64x64x8 frame memory that the VGA pixel generator reads.
- Accepts drawing commands from the GPU core over a valid/ready handshake and turns them into single-pixel write cycles on the frame memory write port.
- Supported commands: single pixel, clipped rectangle fill, full-frame clear.
- The memory is dual-port. This block owns the write port only; the display reads concurrently with no arbitration.

---
 rtl/fb_writer.sv | 186 ++++++++++++++++++
 tb/tb_fb_writer.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fb_writer.sv
// fb_writer: write-side engine for the 64x64x8 frame memory.
//
// Takes drawing commands (PIXEL, clipped RECT fill, full-frame CLEAR) over a
// valid/ready handshake and turns them into one-pixel-per-cycle writes on the
// memory write port. The display side reads the other port independently.
//
// Ports:
//   clock, reset          rising-edge clock, synchronous active-high reset
//   cmd_valid/cmd_ready   command handshake (accept on valid & ready)
//   cmd_op                0=NOP 1=PIXEL 2=RECT 3=CLEAR
//   cmd_x, cmd_y          start column / row
//   cmd_w, cmd_h          rectangle size 0..64 (clipped at the frame edge)
//   cmd_color             pixel value
//   wr_en/addr/data       registered memory write port, addr = {x, y}
//   busy                  a PIXEL or FILL is in progress
module fb_writer #(
  parameter int SIDE_LOG2 = 6,
  parameter int DATA_W    = 8
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [1:0]               cmd_op,
  input  logic [SIDE_LOG2-1:0]     cmd_x,
  input  logic [SIDE_LOG2-1:0]     cmd_y,
  input  logic [SIDE_LOG2:0]       cmd_w,
  input  logic [SIDE_LOG2:0]       cmd_h,
  input  logic [DATA_W-1:0]        cmd_color,
  output logic                     wr_en,
  output logic [2*SIDE_LOG2-1:0]   wr_addr,
  output logic [DATA_W-1:0]        wr_data,
  output logic                     busy
);

  localparam logic [1:0] OP_PIXEL = 2'd1;
  localparam logic [1:0] OP_RECT  = 2'd2;
  localparam logic [1:0] OP_CLEAR = 2'd3;

  // Frame side as a (SIDE_LOG2+1)-bit quantity, and small constants sized to match.
  localparam logic [SIDE_LOG2:0]   SIDE     = {1'b1, {SIDE_LOG2{1'b0}}};
  localparam logic [SIDE_LOG2:0]   WIDE_ONE = {{SIDE_LOG2{1'b0}}, 1'b1};
  localparam logic [SIDE_LOG2-1:0] CNT_ONE  = {{(SIDE_LOG2-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE, PIXEL, FILL} state_t;

  state_t                  state_reg, state_next;
  logic [SIDE_LOG2-1:0]    x_cnt_reg, x_cnt_next;
  logic [SIDE_LOG2-1:0]    y_cnt_reg, y_cnt_next;
  logic [SIDE_LOG2-1:0]    x0_reg, x0_next;
  logic [SIDE_LOG2-1:0]    x_last_reg, x_last_next;
  logic [SIDE_LOG2-1:0]    y_last_reg, y_last_next;
  logic [DATA_W-1:0]       color_reg, color_next;
  logic                    wr_en_reg, wr_en_next;
  logic [2*SIDE_LOG2-1:0]  wr_addr_reg, wr_addr_next;
  logic [DATA_W-1:0]       wr_data_reg, wr_data_next;

  logic accept;

  // Fill geometry at acceptance: CLEAR is a RECT covering the whole frame.
  logic [SIDE_LOG2-1:0] fill_x, fill_y;
  logic [SIDE_LOG2:0]   fill_w, fill_h;
  logic [SIDE_LOG2:0]   room_x, room_y;
  logic [SIDE_LOG2:0]   w_eff, h_eff;
  logic [SIDE_LOG2:0]   x_end_wide, y_end_wide;
  logic                 at_x_end, at_y_end;

  assign cmd_ready = (state_reg == IDLE) & ~reset;
  assign accept    = cmd_valid & cmd_ready;
  assign busy      = (state_reg != IDLE);

  assign fill_x = (cmd_op == OP_CLEAR) ? '0 : cmd_x;
  assign fill_y = (cmd_op == OP_CLEAR) ? '0 : cmd_y;
  assign fill_w = (cmd_op == OP_CLEAR) ? SIDE : cmd_w;
  assign fill_h = (cmd_op == OP_CLEAR) ? SIDE : cmd_h;

  // Clip so the scan never crosses column/row 63 (room is 1..64, no overflow).
  assign room_x = SIDE - {1'b0, fill_x};
  assign room_y = SIDE - {1'b0, fill_y};
  assign w_eff  = (fill_w < room_x) ? fill_w : room_x;
  assign h_eff  = (fill_h < room_y) ? fill_h : room_y;

  // Last column/row of the fill; only used when w_eff, h_eff are nonzero,
  // so the result always fits in SIDE_LOG2 bits.
  assign x_end_wide = {1'b0, fill_x} + w_eff - WIDE_ONE;
  assign y_end_wide = {1'b0, fill_y} + h_eff - WIDE_ONE;

  // End tests compare against latched bounds rather than counter wrap.
  assign at_x_end = (x_cnt_reg == x_last_reg);
  assign at_y_end = (y_cnt_reg == y_last_reg);

  always_comb begin
    state_next   = state_reg;
    x_cnt_next   = x_cnt_reg;
    y_cnt_next   = y_cnt_reg;
    x0_next      = x0_reg;
    x_last_next  = x_last_reg;
    y_last_next  = y_last_reg;
    color_next   = color_reg;
    wr_en_next   = 1'b0;
    wr_addr_next = wr_addr_reg;
    wr_data_next = wr_data_reg;

    case (state_reg)
      IDLE: begin
        if (accept) begin
          if (cmd_op == OP_PIXEL) begin
            state_next   = PIXEL;
            wr_en_next   = 1'b1;
            wr_addr_next = {cmd_x, cmd_y};
            wr_data_next = cmd_color;
          end else if ((cmd_op == OP_CLEAR) ||
                       ((cmd_op == OP_RECT) && (w_eff != '0) && (h_eff != '0))) begin
            // The first write of the fill goes out on the accept edge.
            state_next   = FILL;
            x0_next      = fill_x;
            x_cnt_next   = fill_x;
            y_cnt_next   = fill_y;
            x_last_next  = x_end_wide[SIDE_LOG2-1:0];
            y_last_next  = y_end_wide[SIDE_LOG2-1:0];
            color_next   = cmd_color;
            wr_en_next   = 1'b1;
            wr_addr_next = {fill_x, fill_y};
            wr_data_next = cmd_color;
          end
          // NOP and empty RECT are consumed without effect.
        end
      end

      PIXEL: begin
        state_next = IDLE;
      end

      FILL: begin
        if (at_x_end && at_y_end) begin
          state_next = IDLE;
        end else begin
          if (at_x_end) begin
            x_cnt_next = x0_reg;
            y_cnt_next = y_cnt_reg + CNT_ONE;
          end else begin
            x_cnt_next = x_cnt_reg + CNT_ONE;
          end
          wr_en_next   = 1'b1;
          wr_addr_next = {x_cnt_next, y_cnt_next};
          wr_data_next = color_reg;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg   <= IDLE;
      x_cnt_reg   <= '0;
      y_cnt_reg   <= '0;
      x0_reg      <= '0;
      x_last_reg  <= '0;
      y_last_reg  <= '0;
      color_reg   <= '0;
      wr_en_reg   <= 1'b0;
      wr_addr_reg <= '0;
      wr_data_reg <= '0;
    end else begin
      state_reg   <= state_next;
      x_cnt_reg   <= x_cnt_next;
      y_cnt_reg   <= y_cnt_next;
      x0_reg      <= x0_next;
      x_last_reg  <= x_last_next;
      y_last_reg  <= y_last_next;
      color_reg   <= color_next;
      wr_en_reg   <= wr_en_next;
      wr_addr_reg <= wr_addr_next;
      wr_data_reg <= wr_data_next;
    end
  end

  assign wr_en   = wr_en_reg;
  assign wr_addr = wr_addr_reg;
  assign wr_data = wr_data_reg;

endmodule

// File: tb/tb_fb_writer.sv
// Testbench for fb_writer. Expected writes are pushed onto a scoreboard queue
// when a command is issued; a negedge monitor pops and compares each write.
module tb_fb_writer;

  logic        clock;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [5:0]  cmd_x;
  logic [5:0]  cmd_y;
  logic [6:0]  cmd_w;
  logic [6:0]  cmd_h;
  logic [7:0]  cmd_color;
  logic        wr_en;
  logic [11:0] wr_addr;
  logic [7:0]  wr_data;
  logic        busy;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int write_count = 0;
  int first_write_cyc = 0;
  int last_write_cyc  = 0;
  int accept_cyc = 0;

  logic [19:0] exp_q[$];

  fb_writer #(.SIDE_LOG2(6), .DATA_W(8)) dut (
    .clock(clock), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_x(cmd_x), .cmd_y(cmd_y), .cmd_w(cmd_w), .cmd_h(cmd_h),
    .cmd_color(cmd_color),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  // Scoreboard monitor: every write cycle must match the head of the queue.
  always @(negedge clock) begin
    if (wr_en === 1'b1) begin
      if (write_count == 0) first_write_cyc = cyc;
      write_count++;
      last_write_cyc = cyc;
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_write got addr=%h data=%h, required no write", wr_addr, wr_data);
      end else begin
        logic [19:0] e;
        e = exp_q.pop_front();
        if ({wr_addr, wr_data} !== e) begin
          failures++;
          $display("FAIL write_value got addr=%h data=%h, required addr=%h data=%h",
                   wr_addr, wr_data, e[19:8], e[7:0]);
        end
      end
    end
  end

  task automatic push_rect(input int x0, input int y0, input int w, input int h, input logic [7:0] c);
    for (int yy = y0; yy < y0 + h; yy++)
      for (int xx = x0; xx < x0 + w; xx++) begin
        logic [5:0] ax, ay;
        ax = 6'(xx);
        ay = 6'(yy);
        exp_q.push_back({ax, ay, c});
      end
  endtask

  // Drives one command; waits (bounded) for cmd_ready, then scrambles the
  // fields after acceptance so the DUT must rely on its latched copy.
  task automatic send_cmd(input logic [1:0] op, input logic [5:0] x, input logic [5:0] y,
                          input logic [6:0] w, input logic [6:0] h, input logic [7:0] c,
                          output bit timed_out);
    int n;
    timed_out = 1'b0;
    cmd_op = op; cmd_x = x; cmd_y = y; cmd_w = w; cmd_h = h; cmd_color = c;
    cmd_valid = 1'b1;
    n = 0;
    while (cmd_ready !== 1'b1 && n < 50) begin
      @(posedge clock); #1; n++;
    end
    if (n >= 50) timed_out = 1'b1;
    @(posedge clock); #1;
    accept_cyc = cyc;
    cmd_valid = 1'b0;
    cmd_op = 2'($urandom_range(0, 3)); cmd_x = 6'($urandom); cmd_y = 6'($urandom);
    cmd_w = 7'($urandom_range(0, 64)); cmd_h = 7'($urandom_range(0, 64)); cmd_color = 8'($urandom);
    $display("cmd op=%0d x=%0d y=%0d w=%0d h=%0d color=%h accepted at cycle %0d",
             op, x, y, w, h, c, accept_cyc);
  endtask

  // Counts busy cycles from now until idle; bounded.
  task automatic wait_idle(input int budget, output int busy_cycles, output bit timed_out);
    busy_cycles = 0;
    timed_out = 1'b0;
    while (busy === 1'b1 && busy_cycles < budget) begin
      busy_cycles++;
      @(posedge clock); #1;
    end
    if (busy === 1'b1) timed_out = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    cmd_valid = 1'b1; cmd_op = 2'd1; cmd_x = 6'd7; cmd_y = 6'd7;
    cmd_w = 7'd1; cmd_h = 7'd1; cmd_color = 8'hFF;
    repeat (3) @(posedge clock);
    #1;
    checks++;
    if (cmd_ready !== 1'b0) begin failures++; $display("FAIL reset_ready got %b, required 0", cmd_ready); end
    checks++;
    if ({wr_en, wr_addr, wr_data, busy} !== 22'd0) begin
      failures++;
      $display("FAIL reset_outputs got wr_en=%b addr=%h data=%h busy=%b, required all 0", wr_en, wr_addr, wr_data, busy);
    end
    cmd_valid = 1'b0;
    reset = 1'b0;
    #1;
    checks++;
    if (cmd_ready !== 1'b1) begin failures++; $display("FAIL ready_after_reset got %b, required 1", cmd_ready); end
    @(posedge clock); #1;
    $display("reset done at cycle %0d", cyc);
  endtask

  task automatic test_pixel();
    bit to;
    int wc0;
    wc0 = write_count;
    push_rect(5, 9, 1, 1, 8'hA5);
    send_cmd(2'd1, 6'd5, 6'd9, 7'd0, 7'd0, 8'hA5, to);
    checks++;
    if (to) begin failures++; $display("FAIL pixel_accept got timeout, required accept"); end
    checks++;
    if (wr_en !== 1'b1 || wr_addr !== 12'h149 || wr_data !== 8'hA5) begin
      failures++;
      $display("FAIL pixel_write got wr_en=%b addr=%h data=%h, required 1 149 a5", wr_en, wr_addr, wr_data);
    end
    checks++;
    if (cmd_ready !== 1'b0 || busy !== 1'b1) begin
      failures++; $display("FAIL pixel_busy got ready=%b busy=%b, required 0 1", cmd_ready, busy);
    end
    @(posedge clock); #1;
    checks++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0 || wr_en !== 1'b0) begin
      failures++; $display("FAIL pixel_done got ready=%b busy=%b wr_en=%b, required 1 0 0", cmd_ready, busy, wr_en);
    end
    checks++;
    if (wr_addr !== 12'h149 || wr_data !== 8'hA5) begin
      failures++; $display("FAIL pixel_hold got addr=%h data=%h, required 149 a5", wr_addr, wr_data);
    end
    repeat (2) @(posedge clock); #1;
    checks++;
    if (write_count - wc0 != 1 || last_write_cyc != accept_cyc) begin
      failures++; $display("FAIL pixel_count got writes=%0d at cycle %0d, required 1 at %0d",
                           write_count - wc0, last_write_cyc, accept_cyc);
    end
  endtask

  task automatic test_fill(input string name, input logic [1:0] op, input int x, input int y,
                           input int w, input int h, input int ex0, input int ey0,
                           input int ew, input int eh, input logic [7:0] c);
    bit to;
    int bc, wc0, fc0;
    wc0 = write_count;
    push_rect(ex0, ey0, ew, eh, c);
    send_cmd(op, 6'(x), 6'(y), 7'(w), 7'(h), c, to);
    fc0 = accept_cyc;
    checks++;
    if (to) begin failures++; $display("FAIL %s_accept got timeout, required accept", name); end
    wait_idle(5000, bc, to);
    checks++;
    if (to || bc != ew * eh) begin
      failures++; $display("FAIL %s_busy got %0d busy cycles (timeout=%0b), required %0d", name, bc, to, ew * eh);
    end
    repeat (2) @(posedge clock); #1;
    checks++;
    if (write_count - wc0 != ew * eh || last_write_cyc - fc0 != ew * eh - 1) begin
      failures++; $display("FAIL %s_writes got %0d writes ending cycle %0d, required %0d ending %0d",
                           name, write_count - wc0, last_write_cyc, ew * eh, fc0 + ew * eh - 1);
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++; $display("FAIL %s_missing got %0d writes outstanding, required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_null(input string name, input logic [1:0] op, input int w, input int h);
    bit to;
    int wc0;
    bit bad;
    wc0 = write_count;
    send_cmd(op, 6'd10, 6'd20, 7'(w), 7'(h), 8'h77, to);
    bad = to;
    for (int i = 0; i < 4; i++) begin
      if (cmd_ready !== 1'b1 || busy !== 1'b0 || wr_en !== 1'b0) bad = 1'b1;
      @(posedge clock); #1;
    end
    checks++;
    if (bad || write_count != wc0) begin
      failures++; $display("FAIL %s got writes=%0d ready=%b busy=%b, required no effect",
                           name, write_count - wc0, cmd_ready, busy);
    end
  endtask

  task automatic test_back_to_back();
    bit to1, to2;
    int a1, wc0;
    wc0 = write_count;
    push_rect(3, 4, 1, 1, 8'h01);
    push_rect(60, 2, 1, 1, 8'h02);
    send_cmd(2'd1, 6'd3, 6'd4, 7'd0, 7'd0, 8'h01, to1);
    a1 = accept_cyc;
    send_cmd(2'd1, 6'd60, 6'd2, 7'd0, 7'd0, 8'h02, to2);
    checks++;
    if (to1 || to2 || accept_cyc - a1 != 2) begin
      failures++; $display("FAIL b2b_spacing got %0d cycles between accepts, required 2", accept_cyc - a1);
    end
    repeat (3) @(posedge clock); #1;
    checks++;
    if (write_count - wc0 != 2 || exp_q.size() != 0) begin
      failures++; $display("FAIL b2b_writes got %0d writes, required 2", write_count - wc0);
      exp_q.delete();
    end
  endtask

  task automatic test_reset_mid_clear();
    bit to;
    int wc0;
    wc0 = write_count;
    push_rect(0, 0, 64, 1, 8'h3C);
    push_rect(0, 1, 36, 1, 8'h3C);     // the first 100 writes in scan order
    send_cmd(2'd3, 6'd9, 6'd9, 7'd3, 7'd3, 8'h3C, to);
    repeat (99) @(posedge clock);
    #1;
    reset = 1'b1;                      // held through the 100th write cycle
    @(posedge clock); #1;
    reset = 1'b0;
    checks++;
    if (wr_en !== 1'b0 || busy !== 1'b0) begin
      failures++; $display("FAIL reset_mid_clear got wr_en=%b busy=%b, required 0 0", wr_en, busy);
    end
    repeat (5) @(posedge clock); #1;
    checks++;
    if (write_count - wc0 != 100 || exp_q.size() != 0) begin
      failures++; $display("FAIL reset_mid_count got %0d writes, required 100", write_count - wc0);
      exp_q.delete();
    end
    wc0 = write_count;
    push_rect(1, 1, 1, 1, 8'h5A);
    send_cmd(2'd1, 6'd1, 6'd1, 7'd0, 7'd0, 8'h5A, to);
    checks++;
    if (to || wr_en !== 1'b1 || wr_addr !== 12'h041) begin
      failures++; $display("FAIL post_reset_pixel got wr_en=%b addr=%h, required 1 041", wr_en, wr_addr);
    end
    repeat (2) @(posedge clock); #1;
    checks++;
    if (write_count - wc0 != 1 || exp_q.size() != 0) begin
      failures++; $display("FAIL post_reset_count got %0d writes, required 1", write_count - wc0);
    end
  endtask

  initial begin
    reset = 1'b1;
    cmd_valid = 1'b0;
    cmd_op = 2'd0; cmd_x = '0; cmd_y = '0; cmd_w = '0; cmd_h = '0; cmd_color = '0;
    test_reset();
    test_pixel();
    test_fill("rect", 2'd2, 2, 3, 3, 2, 2, 3, 3, 2, 8'h11);
    test_fill("clip", 2'd2, 62, 63, 5, 4, 62, 63, 2, 1, 8'h22);
    test_fill("full_rect", 2'd2, 0, 0, 64, 1, 0, 0, 64, 1, 8'h33);
    test_fill("clear", 2'd3, 17, 40, 2, 2, 0, 0, 64, 64, 8'h00);
    test_null("rect_w0", 2'd2, 0, 7);
    test_null("nop", 2'd0, 5, 5);
    test_back_to_back();
    test_reset_mid_clear();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global watchdog so the run always terminates.
  initial begin
    #2000000;
    $display("FAIL watchdog got timeout, required completion");
    $fatal(1, "watchdog");
  end

endmodule
